// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared widths, state encodings and timeout default
package dmem_access_ctrl_pkg;
  localparam int CPU_W = 32;
  localparam int TIMEOUT_DEFAULT = 255;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } dmem_st_e;
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: external data bus with request/grant and response-valid handshake
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;
  logic             bus_req_o;
  logic             bus_we_o;
  logic [CPU_W-1:0] bus_addr_o;
  logic [CPU_W-1:0] bus_wdata_o;
  logic             bus_gnt_i;
  logic             bus_rvalid_i;
  logic [CPU_W-1:0] bus_rdata_i;
  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: clearable, enabled wait counter with terminal-count flag
module dmem_timeout_cnt #(
  parameter int TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TERM = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TO_WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = cnt == TERM;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: runs one word-level memory request on the external bus,
// stalls the pipeline while it is outstanding and flags bus timeouts
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH   = CPU_W,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter int TO_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req_i,
  input  logic                 mem_wr_en_i,
  input  logic [CPU_WIDTH-1:0] mem_addr_i,
  input  logic [CPU_WIDTH-1:0] mem_wdata_i,
  output logic [CPU_WIDTH-1:0] mem_rdata_o,
  output logic                 access_hold_o,
  output logic                 access_err_o,
  dmem_access_ctrl_if.master   bus
);
  dmem_st_e st, nxt;
  logic [CPU_WIDTH-1:0] addr_q, wdata_q;
  logic we_q, tc, done_ok, abort;
  always_ff @(posedge clk)
    st <= rst ? ST_IDLE : nxt;
  always_comb begin
    done_ok = (st == ST_REQ && bus.bus_gnt_i && bus.bus_rvalid_i) || (st == ST_RSP && bus.bus_rvalid_i);
    abort = tc && ((st == ST_REQ && !bus.bus_gnt_i) || (st == ST_RSP && !bus.bus_rvalid_i));
    nxt = st == ST_IDLE ? (mem_req_i ? ST_REQ : ST_IDLE)
        : st == ST_DONE ? ST_IDLE
        : (done_ok || abort) ? ST_DONE
        : (st == ST_REQ && bus.bus_gnt_i) ? ST_RSP : st;
    access_hold_o = st == ST_IDLE ? mem_req_i : st != ST_DONE;
    bus.bus_req_o = st == ST_REQ;
  end
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;
  always_ff @(posedge clk)
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      mem_rdata_o <= '0;
      access_err_o <= 1'b0;
    end else begin
      access_err_o <= abort;
      if (st == ST_IDLE && mem_req_i) begin
        addr_q <= {mem_addr_i[CPU_WIDTH-1:2], 2'b00};
        wdata_q <= mem_wdata_i;
        we_q <= mem_wr_en_i;
      end
      // writes complete on rvalid but must not disturb the last read word
      if (abort) mem_rdata_o <= '0;
      else if (done_ok && !we_q) mem_rdata_o <= bus.bus_rdata_i;
    end
  dmem_timeout_cnt #(
    .TO_WIDTH(TO_WIDTH),
    .TERM(TO_WIDTH'(TIMEOUT_CYC - 1))
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(st != nxt),
    .en(st == ST_REQ || st == ST_RSP),
    .tc(tc)
  );
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vectors for the data-memory access controller
module tb_dmem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata_o;
  logic hold, err;
  int errs = 0, checks = 0;
  dmem_access_ctrl_if bif ();
  dmem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_wr_en_i(we), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_rdata_o(rdata_o), .access_hold_o(hold),
    .access_err_o(err), .bus(bif.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bif.bus_gnt_i = 1'b0;
    bif.bus_rvalid_i = 1'b0;
    bif.bus_rdata_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_hold", hold, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_bus_req", bif.bus_req_o, 0);
    chk("rst_bus_addr", bif.bus_addr_o, 0);
    // read, one-cycle grant and rvalid
    req = 1; we = 0; addr = 32'h8000_0006;
    #1 chk("rd_hold_idle", hold, 1);
    tick();
    chk("rd_bus_req", bif.bus_req_o, 1);
    chk("rd_bus_addr", bif.bus_addr_o, 32'h8000_0004);
    chk("rd_bus_we", bif.bus_we_o, 0);
    chk("rd_hold_req", hold, 1);
    bif.bus_gnt_i = 1;
    tick();
    bif.bus_gnt_i = 0;
    chk("rd_req_drop", bif.bus_req_o, 0);
    chk("rd_hold_rsp", hold, 1);
    bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'hDEAD_BEEF;
    tick();
    bif.bus_rvalid_i = 0;
    chk("rd_hold_done", hold, 0);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", err, 0);
    req = 0;
    tick();
    chk("rd_idle_hold", hold, 0);
    // write with grant delayed 4 cycles
    req = 1; we = 1; addr = 32'h10; wdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_bus_req_wait", bif.bus_req_o, 1);
      chk("wr_hold_wait", hold, 1);
      chk("wr_bus_we", bif.bus_we_o, 1);
      tick();
    end
    chk("wr_bus_req_5th", bif.bus_req_o, 1);
    chk("wr_bus_wdata", bif.bus_wdata_o, 32'h1234_5678);
    chk("wr_bus_addr", bif.bus_addr_o, 32'h10);
    bif.bus_gnt_i = 1;
    tick();
    bif.bus_gnt_i = 0;
    chk("wr_req_drop", bif.bus_req_o, 0);
    chk("wr_hold_rsp", hold, 1);
    bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'hFFFF_0000;
    tick();
    bif.bus_rvalid_i = 0;
    chk("wr_hold_done", hold, 0);
    chk("wr_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    req = 0;
    tick();
    // grant and rvalid together
    req = 1; we = 0; addr = 32'h20;
    tick();
    chk("gr_hold_req", hold, 1);
    chk("gr_bus_addr", bif.bus_addr_o, 32'h20);
    bif.bus_gnt_i = 1; bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'hCAFE_F00D;
    tick();
    bif.bus_gnt_i = 0; bif.bus_rvalid_i = 0;
    chk("gr_hold_done", hold, 0);
    chk("gr_rdata", rdata_o, 32'hCAFE_F00D);
    chk("gr_bus_req", bif.bus_req_o, 0);
    req = 0;
    tick();
    // timeout with no grant
    req = 1; we = 0; addr = 32'h30;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_bus_req", bif.bus_req_o, 1);
      chk("to_err_early", err, 0);
      tick();
    end
    chk("to_err", err, 1);
    chk("to_rdata", rdata_o, 0);
    chk("to_hold", hold, 0);
    chk("to_bus_req_off", bif.bus_req_o, 0);
    req = 0;
    tick();
    chk("to_err_pulse", err, 0);
    chk("to_idle_hold", hold, 0);
    // read-modify-write on consecutive requests
    req = 1; we = 0; addr = 32'h40;
    tick();
    bif.bus_gnt_i = 1;
    tick();
    bif.bus_gnt_i = 0;
    bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'hA5A5_0011;
    tick();
    bif.bus_rvalid_i = 0;
    chk("rmw_rd_rdata", rdata_o, 32'hA5A5_0011);
    chk("rmw_rd_hold", hold, 0);
    we = 1; wdata = 32'hA5A5_FF11;
    tick();
    chk("rmw_idle_bus_req", bif.bus_req_o, 0);
    chk("rmw_idle_hold", hold, 1);
    tick();
    chk("rmw_wr_bus_req", bif.bus_req_o, 1);
    chk("rmw_wr_we", bif.bus_we_o, 1);
    chk("rmw_wr_addr", bif.bus_addr_o, 32'h40);
    chk("rmw_wr_wdata", bif.bus_wdata_o, 32'hA5A5_FF11);
    bif.bus_gnt_i = 1;
    tick();
    bif.bus_gnt_i = 0;
    bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'h0BAD_0BAD;
    tick();
    bif.bus_rvalid_i = 0;
    chk("rmw_wr_hold", hold, 0);
    chk("rmw_wr_rdata", rdata_o, 32'hA5A5_0011);
    req = 0;
    tick();
    // reset during RSP, rvalid arriving afterwards
    req = 1; we = 0; addr = 32'h50;
    tick();
    bif.bus_gnt_i = 1;
    tick();
    bif.bus_gnt_i = 0;
    chk("rr_hold_rsp", hold, 1);
    rst = 1; req = 0;
    tick();
    rst = 0;
    bif.bus_rvalid_i = 1; bif.bus_rdata_i = 32'h1111_2222;
    #1;
    chk("rr_hold", hold, 0);
    chk("rr_bus_req", bif.bus_req_o, 0);
    chk("rr_err", err, 0);
    chk("rr_rdata", rdata_o, 0);
    chk("rr_bus_addr", bif.bus_addr_o, 0);
    chk("rr_bus_we", bif.bus_we_o, 0);
    chk("rr_bus_wdata", bif.bus_wdata_o, 0);
    tick();
    bif.bus_rvalid_i = 0;
    chk("rr_rdata_ignored", rdata_o, 0);
    chk("rr_err_after", err, 0);
    chk("rr_hold_after", hold, 0);
    chk("rr_bus_req_after", bif.bus_req_o, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
